// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
//
// Shared definitions for the SHA-256 datapath: the 32-bit word type, the
// schedule/round counts, the small-sigma rotate/shift amounts and the s0/s1
// functions. The compression stage imports the same s0/s1 so both stages
// agree bit-for-bit.
//
// No ports (package).
// -----------------------------------------------------------------------------
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SCHED_WORDS   = 16;
    localparam int SHA256_ROUNDS = 64;

    // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
    localparam int unsigned S0_ROT_A = 7;
    localparam int unsigned S0_ROT_B = 18;
    localparam int unsigned S0_SHR   = 3;
    // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
    localparam int unsigned S1_ROT_A = 17;
    localparam int unsigned S1_ROT_B = 19;
    localparam int unsigned S1_SHR   = 10;

    // Message-schedule FSM encoding.
    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t s0(input word_t x);
        return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
    endfunction

    function automatic word_t s1(input word_t x);
        return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule_if
//
// Bundles the message-input and schedule-output handshakes of the SHA-256
// message scheduler plus its status flags.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The sender keeps data stable while
// valid is high and ready is low; ready never depends combinationally on
// valid.
//
// Signals:
//   MsgValid / MsgReady / MsgWord : 32-bit message words into the scheduler
//   WValid / WReady / WData / WIndex : schedule words Wt out, t in WIndex
//   Busy : scheduler is expanding a block
//   Done : one-cycle pulse after the last schedule word is accepted
// Modports: master (block source / word consumer), slave (the scheduler).
// -----------------------------------------------------------------------------
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic       MsgValid;
    logic       MsgReady;
    word_t      MsgWord;
    logic       WValid;
    logic       WReady;
    word_t      WData;
    logic [5:0] WIndex;
    logic       Busy;
    logic       Done;

    modport master (
        output MsgValid, MsgWord, WReady,
        input  MsgReady, WValid, WData, WIndex, Busy, Done
    );

    modport slave (
        input  MsgValid, MsgWord, WReady,
        output MsgReady, WValid, WData, WIndex, Busy, Done
    );

endinterface

// File: rtl/ThirtytwobitAdder.sv
// -----------------------------------------------------------------------------
// ThirtytwobitAdder
//
// 32-bit modular adder shared across the SHA-256 datapath; the carry out is
// discarded (arithmetic mod 2^32).
//
// Ports:
//   a_i, b_i : 32-bit operands
//   sum_o    : (a_i + b_i) mod 2^32
// -----------------------------------------------------------------------------
module ThirtytwobitAdder
    import sha256_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    output word_t sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/sha256_sched_sum.sv
// -----------------------------------------------------------------------------
// sha256_sched_sum
//
// Combinational next-word generator for the message schedule:
//   New = s1(Win14) + Win9 + s0(Win1) + Win0   (mod 2^32)
// built as a two-level tree of ThirtytwobitAdder instances so the adder
// structure matches the compression stage.
//
// Ports:
//   win0_i, win1_i, win9_i, win14_i : taps of the 16-word sliding window
//   sum_o                           : next schedule word
// -----------------------------------------------------------------------------
module sha256_sched_sum
    import sha256_pkg::*;
(
    input  word_t win0_i,
    input  word_t win1_i,
    input  word_t win9_i,
    input  word_t win14_i,
    output word_t sum_o
);

    word_t sig0;
    word_t sig1;
    word_t sum_a;
    word_t sum_b;

    assign sig0 = s0(win1_i);
    assign sig1 = s1(win14_i);

    ThirtytwobitAdder u_add_s1 (
        .a_i   (sig1),
        .b_i   (win9_i),
        .sum_o (sum_a)
    );

    ThirtytwobitAdder u_add_s0 (
        .a_i   (sig0),
        .b_i   (win0_i),
        .sum_o (sum_b)
    );

    ThirtytwobitAdder u_add_final (
        .a_i   (sum_a),
        .b_i   (sum_b),
        .sum_o (sum_o)
    );

endmodule

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
//
// SHA-256 message-schedule expander. Loads one 512-bit block as 16 32-bit
// words (M0 first), then emits W0..W(NUM_ROUNDS-1), one word per handshake,
// from a 16-word sliding window. Win[0] is always the word on offer.
//
// Build option: define SHA256_SCHED_BYTESWAP_EN to byte-reverse each MsgWord
// before it is stored (little-endian hosts). Only the load path changes.
//
// Parameters:
//   NUM_ROUNDS : schedule words per block (16..64, 64 for SHA-256)
//
// Ports:
//   Clock       : rising-edge clock
//   Reset       : asynchronous, active-high
//   bus         : sha256_msg_schedule_if.slave (message in, Wt out, Busy, Done)
//   dbg_state_o : current FSM state (ST_LOAD / ST_EXPAND)
// -----------------------------------------------------------------------------
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA256_ROUNDS
) (
    input  logic                   Clock,
    input  logic                   Reset,
    sha256_msg_schedule_if.slave   bus,
    output logic [0:0]             dbg_state_o
);

    logic [0:0] state_q, state_d;
    logic [3:0] load_cnt_q, load_cnt_d;
    logic [5:0] idx_q, idx_d;
    logic       done_q, done_d;
    word_t      win_q [SCHED_WORDS];
    word_t      win_d [SCHED_WORDS];

    word_t      new_word;
    word_t      load_word;
    logic       msg_fire;
    logic       w_fire;
    logic       last_fire;
    logic       refill;

    sha256_sched_sum u_sum (
        .win0_i  (win_q[0]),
        .win1_i  (win_q[1]),
        .win9_i  (win_q[9]),
        .win14_i (win_q[14]),
        .sum_o   (new_word)
    );

`ifdef SHA256_SCHED_BYTESWAP_EN
    assign load_word = {bus.MsgWord[7:0], bus.MsgWord[15:8],
                        bus.MsgWord[23:16], bus.MsgWord[31:24]};
`else
    assign load_word = bus.MsgWord;
`endif

    // Ready/valid are decoded from state only, so neither handshake input
    // reaches an output combinationally.
    assign msg_fire  = bus.MsgValid && (state_q == ST_LOAD);
    assign w_fire    = bus.WReady && (state_q == ST_EXPAND);
    assign last_fire = w_fire && (idx_q == 6'(NUM_ROUNDS - 1));
    // Only the first NUM_ROUNDS-16 shifts bring in a newly computed word;
    // after that the window just drains and zeros fill the tail.
    assign refill    = (int'(idx_q) < (NUM_ROUNDS - SCHED_WORDS));

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        win_d      = win_q;

        case (state_q)
            ST_LOAD: begin
                if (msg_fire) begin
                    win_d[load_cnt_q] = load_word;
                    if (load_cnt_q == 4'd15) begin
                        state_d    = ST_EXPAND;
                        load_cnt_d = 4'd0;
                        idx_d      = 6'd0;
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end
            end
            ST_EXPAND: begin
                if (w_fire) begin
                    for (int i = 0; i < SCHED_WORDS - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[SCHED_WORDS-1] = refill ? new_word : '0;
                    if (last_fire) begin
                        state_d = ST_LOAD;
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 4'd0;
            idx_q      <= 6'd0;
            done_q     <= 1'b0;
            for (int i = 0; i < SCHED_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            for (int i = 0; i < SCHED_WORDS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.MsgReady = (state_q == ST_LOAD);
    assign bus.WValid   = (state_q == ST_EXPAND);
    assign bus.Busy     = (state_q == ST_EXPAND);
    assign bus.WData    = win_q[0];
    assign bus.WIndex   = idx_q;
    assign bus.Done     = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
//
// Self-checking bench for sha256_msg_schedule. The reference model is the
// textbook SHA-256 schedule recurrence over a 64-entry array; expected
// words go into exp_q, host-form message words into send_q.
// -----------------------------------------------------------------------------
module tb_sha256_msg_schedule;
    import sha256_pkg::*;

    localparam int NR = 64;

    // ---------------- clock / reset ----------------
    logic       Clock;
    logic       Reset;
    logic [0:0] dbg_state;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule #(.NUM_ROUNDS(NR)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] send_q[$];
    logic [31:0] got_w[NR];
    logic [31:0] abc_blk[16];
    logic [31:0] zero_blk[16];
    logic [31:0] rnd_blk[16];

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] dbl;
        dbl = {x, x};
        return dbl[n +: 32];
    endfunction

    function automatic logic [31:0] m_sig0(input logic [31:0] x);
        return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_sig1(input logic [31:0] x);
        return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] host_form(input logic [31:0] be);
`ifdef SHA256_SCHED_BYTESWAP_EN
        return {be[7:0], be[15:8], be[23:16], be[31:24]};
`else
        return be;
`endif
    endfunction

    task automatic queue_block(input logic [31:0] m[16]);
        logic [31:0] w[64];
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++)
            w[t] = m_sig1(w[t-2]) + w[t-7] + m_sig0(w[t-15]) + w[t-16];
        for (int t = 0; t < NR; t++) exp_q.push_back(w[t]);
        for (int t = 0; t < 16; t++) send_q.push_back(host_form(m[t]));
    endtask

    // ---------------- driver + checker loop ----------------
    // Each cycle, at the falling edge: drive inputs, compare outputs against
    // the model's expected phase, then account for handshakes that the next
    // rising edge will perform.
    task automatic run_stream(input int gap_pct, input int ready_pct,
                              input int stop_idx, output bit stopped,
                              output int hs);
        int          cycles     = 0;
        int          exp_idx    = 0;
        int          loaded     = 0;
        bit          exp_expand = 1'b0;
        bit          done_exp   = 1'b0;
        bit          hold       = 1'b0;
        bit          cur_expand;
        logic [31:0] hold_d     = '0;
        logic [5:0]  hold_i     = '0;
        stopped = 1'b0;
        hs      = 0;
        for (int i = 0; i < NR; i++) got_w[i] = '0;
        while (1) begin
            @(negedge Clock);
            cycles++;
            if (cycles > 4000) begin
                errors++;
                $display("FAIL timeout: cycles=%0d words_left=%0d required=0", cycles, exp_q.size());
                break;
            end
            if (send_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                bus.MsgValid = 1'b1;
                bus.MsgWord  = send_q[0];
            end else begin
                bus.MsgValid = 1'b0;
                bus.MsgWord  = $urandom;
            end
            bus.WReady = ($urandom_range(99) < ready_pct);
            cur_expand = exp_expand;

            checks++;
            if (bus.WValid !== cur_expand || bus.Busy !== cur_expand ||
                bus.MsgReady !== !cur_expand) begin
                errors++;
                $display("FAIL phase: WValid=%b Busy=%b MsgReady=%b required WValid=%b Busy=%b MsgReady=%b",
                         bus.WValid, bus.Busy, bus.MsgReady, cur_expand, cur_expand, !cur_expand);
            end
            checks++;
            if (bus.Done !== done_exp) begin
                errors++;
                $display("FAIL done: got=%b required=%b", bus.Done, done_exp);
            end
            done_exp = 1'b0;

            if (hold) begin
                checks++;
                if (bus.WData !== hold_d || bus.WIndex !== hold_i) begin
                    errors++;
                    $display("FAIL hold: WData=%h WIndex=%0d required WData=%h WIndex=%0d",
                             bus.WData, bus.WIndex, hold_d, hold_i);
                end
            end
            hold = 1'b0;

            if (cur_expand) begin
                if (stop_idx >= 0 && exp_idx == stop_idx) begin
                    bus.WReady   = 1'b0;
                    bus.MsgValid = 1'b0;
                    stopped      = 1'b1;
                    return;
                end
                checks++;
                if (bus.WData !== exp_q[0] || bus.WIndex !== 6'(exp_idx)) begin
                    errors++;
                    $display("FAIL wword: WData=%h WIndex=%0d required WData=%h WIndex=%0d",
                             bus.WData, bus.WIndex, exp_q[0], exp_idx);
                end
                if (bus.WReady) begin
                    got_w[exp_idx] = bus.WData;
                    void'(exp_q.pop_front());
                    hs++;
                    if (exp_idx == NR - 1) begin
                        exp_idx    = 0;
                        exp_expand = 1'b0;
                        done_exp   = 1'b1;
                    end else begin
                        exp_idx++;
                    end
                end else begin
                    hold   = 1'b1;
                    hold_d = bus.WData;
                    hold_i = bus.WIndex;
                end
            end

            if (bus.MsgValid && !cur_expand) begin
                void'(send_q.pop_front());
                loaded++;
                if (loaded == 16) begin
                    loaded     = 0;
                    exp_expand = 1'b1;
                end
            end

            if (exp_q.size() == 0 && !exp_expand && !done_exp) break;
        end
        bus.MsgValid = 1'b0;
        bus.WReady   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset        = 1'b1;
        bus.MsgValid = 1'b0;
        bus.MsgWord  = '0;
        bus.WReady   = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.MsgReady !== 1'b1 || bus.WValid !== 1'b0 || bus.Busy !== 1'b0 ||
            bus.Done !== 1'b0 || bus.WData !== 32'h0 || bus.WIndex !== 6'd0) begin
            errors++;
            $display("FAIL reset: MsgReady=%b WValid=%b Busy=%b Done=%b WData=%h WIndex=%0d required 1 0 0 0 0 0",
                     bus.MsgReady, bus.WValid, bus.Busy, bus.Done, bus.WData, bus.WIndex);
        end
        Reset = 1'b0;
    endtask

    task automatic test_abc();
        bit st;
        int hs;
        queue_block(abc_blk);
        run_stream(0, 100, -1, st, hs);
        checks++;
        if (got_w[0] !== 32'h61626380 || got_w[16] !== 32'h61626380 ||
            got_w[17] !== 32'h000F0000 || got_w[63] !== 32'h12B1EDEB) begin
            errors++;
            $display("FAIL abc_known: W0=%h W16=%h W17=%h W63=%h required 61626380 61626380 000f0000 12b1edeb",
                     got_w[0], got_w[16], got_w[17], got_w[63]);
        end
    endtask

    task automatic test_zero();
        bit st;
        int hs;
        queue_block(zero_blk);
        run_stream(0, 100, -1, st, hs);
        checks++;
        if (hs !== NR) begin
            errors++;
            $display("FAIL zero_count: handshakes=%0d required=%0d", hs, NR);
        end
    endtask

    task automatic test_abc_random();
        bit st;
        int hs;
        queue_block(abc_blk);
        run_stream(30, 50, -1, st, hs);
        checks++;
        if (got_w[63] !== 32'h12B1EDEB || hs !== NR) begin
            errors++;
            $display("FAIL abc_random: W63=%h handshakes=%0d required 12b1edeb %0d", got_w[63], hs, NR);
        end
    endtask

    task automatic test_reset_mid();
        bit st;
        int hs;
        queue_block(abc_blk);
        run_stream(0, 100, 30, st, hs);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reach: stopped=%b required=1", st);
        end
        exp_q.delete();
        send_q.delete();
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.WValid !== 1'b0 || bus.MsgReady !== 1'b1 || bus.Done !== 1'b0 ||
            bus.WIndex !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid: WValid=%b MsgReady=%b Done=%b WIndex=%0d required 0 1 0 0",
                     bus.WValid, bus.MsgReady, bus.Done, bus.WIndex);
        end
        @(negedge Clock);
        Reset = 1'b0;
        queue_block(abc_blk);
        run_stream(20, 70, -1, st, hs);
        checks++;
        if (got_w[17] !== 32'h000F0000 || hs !== NR) begin
            errors++;
            $display("FAIL reset_reload: W17=%h handshakes=%0d required 000f0000 %0d", got_w[17], hs, NR);
        end
    endtask

    task automatic test_back_to_back();
        bit st;
        int hs;
        for (int k = 0; k < 16; k++) rnd_blk[k] = $urandom;
        queue_block(abc_blk);
        queue_block(rnd_blk);
        run_stream(0, 100, -1, st, hs);
        checks++;
        if (hs !== 2 * NR) begin
            errors++;
            $display("FAIL b2b_count: handshakes=%0d required=%0d", hs, 2 * NR);
        end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) rnd_blk[k] = $urandom;
            queue_block(rnd_blk);
        end
        run_stream($urandom_range(0, 40), $urandom_range(30, 90), -1, st, hs);
        checks++;
        if (hs !== 3 * NR) begin
            errors++;
            $display("FAIL random_count: handshakes=%0d required=%0d", hs, 3 * NR);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int k = 0; k < 16; k++) begin
            abc_blk[k]  = '0;
            zero_blk[k] = '0;
        end
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;

        test_reset();
        test_abc();
        test_zero();
        test_abc_random();
        test_reset_mid();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Message-schedule expander for the SHA-256 datapath.
- Accepts one 512-bit block as 16 big-endian 32-bit words, then emits the 64 schedule words W0..W63 in order, one word per handshake.
- Sits directly upstream of the round/compression stage: each emitted Wt feeds that stage's ThirtytwobitAdder chain (Kt + Wt + ...).
- Internally uses a 16-word sliding window and three 32-bit modular additions per expanded word.

Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block; fixed at 64 for SHA-256, exposed only for bench shortening; legal range 16..64.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- MsgValid  in  1  MsgWord is valid.
- MsgReady  out  1  block accepts a message word this cycle.
- MsgWord  in  32  message word, M0 first, big-endian.
- WValid  out  1  WData/WIndex hold a valid schedule word.
- WReady  in  1  consumer accepts the schedule word this cycle.
- WData  out  32  schedule word Wt.
- WIndex  out  6  t of the current WData.
- Busy  out  1  high while in EXPAND.
- Done  out  1  one-cycle pulse after W(NUM_ROUNDS-1) is accepted.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=LOAD, LoadCnt=0, Idx=0, window Win[0..15]=0, WValid=0, WData=0, WIndex=0, Done=0, Busy=0, MsgReady=1.
- MsgReady = (state==LOAD). WData = Win[0]. WIndex = Idx. All outputs are registered or decoded from registered state; there is no combinational path from MsgValid or WReady to any output.

LOAD state:
- On each MsgValid&&MsgReady: Win[LoadCnt] <= MsgWord; LoadCnt++.
- On the 16th accept (LoadCnt==15): state <= EXPAND, Idx <= 0, LoadCnt <= 0.
- WValid rises the cycle after the 16th accept (latency 1).
- MsgValid low: hold; gaps between words are allowed.

EXPAND state:
- WValid=1, Busy=1.
- On each WValid&&WReady:
  - New = s1(Win[14]) + Win[9] + s0(Win[1]) + Win[0], mod 2^32, carries discarded.
  - Win[i] <= Win[i+1] for i=0..14. Win[15] <= New if Idx<NUM_ROUNDS-16, else 0.
  - Idx++.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- WReady low: WData, WIndex and Win are frozen for any number of cycles.
- Handshake on Idx==NUM_ROUNDS-1: state <= LOAD, WValid <= 0, Done <= 1 for exactly one cycle, Idx <= 0. MsgReady is high on that same cycle, so the next block may begin loading immediately.

Boundary conditions:
- MsgValid asserted during EXPAND: ignored (MsgReady=0), no state change.
- Reset asserted mid-LOAD or mid-EXPAND: immediate return to reset values. The partial block is discarded and no Done is issued.
- Back-to-back blocks: the first word of block N+1 can be accepted in the same cycle Done pulses for block N.

Optional Feature:
- Macro: SHA256_SCHED_BYTESWAP_EN.
- Defined: each MsgWord is byte-reversed before being written to Win ({b0,b1,b2,b3}), supporting little-endian hosts.
- Undefined: MsgWord is stored unchanged.
- Only the LOAD write path differs; expansion and all timing are identical in both builds.

Decomposition:
- Shared package sha256_pkg:
  - word_t (32-bit) typedef.
  - SCHED_WORDS=16 and SHA256_ROUNDS=64.
  - Rotate amounts (7, 18, 3, 17, 19, 10) as named constants.
  - s0/s1 functions, also reused by the compression stage.
- Natural sub-module: sha256_sched_sum.
  - Combinational 4-operand sum built from three ThirtytwobitAdder instances in a tree: (s1+Win9) and (s0+Win0), then a final add.
  - Keeps the adder structure consistent with the rest of the datapath.

Test Plan:
- "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), WReady=1 → W0=0x61626380, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; Done pulses once, the cycle after the W63 handshake.
- All-zero block → all 64 WData = 0x00000000, WIndex 0..63 contiguous, exactly 64 handshakes.
- "abc" with WReady toggling randomly (50%) and MsgValid gaps → identical W sequence to the first test; WData/WIndex stable while WValid&&!WReady.
- Reset asserted at WIndex=30 → next cycle WValid=0, MsgReady=1, Done=0. A subsequent "abc" load produces correct W0..W63.
- Two back-to-back blocks, second word stream starting on the Done cycle → both sequences correct, no lost or duplicated word. MsgWord offered during EXPAND is not consumed.
- SHA256_SCHED_BYTESWAP_EN build: load "abc" as M0=0x80636261, M15=0x18000000 → same W0..W63 as the first test.
